xif_offload_ctrl: RTL and testbench



---
 rtl/xif_offload_ctrl.sv | 171 +++++++++++++++++
 tb/tb_xif_offload_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_offload_ctrl.sv
// Core-side CV-X-IF initiator: issue/commit handshake for one offload at a time,
// outstanding-ID tracking, and a one-entry result-to-writeback buffer.
module xif_offload_ctrl #(
   parameter int unsigned X_NUM_RS        = 2,
   parameter int unsigned X_ID_WIDTH      = 4,
   parameter int unsigned X_RFR_WIDTH     = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            off_valid_i,
   output logic                            off_ready_o,
   input  logic [31:0]                     off_instr_i,
   input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] off_rs_i,
   input  logic                            off_kill_i,
   output logic                            off_done_o,
   output logic                            off_illegal_o,
   output logic                            issue_valid_o,
   input  logic                            issue_ready_i,
   output logic [31:0]                     issue_req_instr_o,
   output logic [1:0]                      issue_req_mode_o,
   output logic [X_ID_WIDTH-1:0]           issue_req_id_o,
   output logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_req_rs_o,
   output logic [X_NUM_RS-1:0]             issue_req_rs_valid_o,
   input  logic                            issue_resp_accept_i,
   input  logic                            issue_resp_writeback_i,
   output logic                            commit_valid_o,
   output logic [X_ID_WIDTH-1:0]           commit_id_o,
   output logic                            commit_kill_o,
   input  logic                            result_valid_i,
   output logic                            result_ready_o,
   input  logic [X_ID_WIDTH-1:0]           result_id_i,
   input  logic [31:0]                     result_data_i,
   input  logic [4:0]                      result_rd_i,
   input  logic                            result_we_i,
   input  logic                            result_exc_i,
   input  logic [5:0]                      result_exccode_i,
   output logic                            wb_valid_o,
   input  logic                            wb_ready_i,
   output logic [4:0]                      wb_rd_o,
   output logic [31:0]                     wb_data_o,
   output logic                            wb_we_o,
   output logic                            wb_exc_o,
   output logic [5:0]                      wb_exccode_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                            proto_err_o
);

   localparam int unsigned CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned NUM_IDS = 2 ** X_ID_WIDTH;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

   state_e                            state_q;
   logic [31:0]                       instr_q;
   logic [X_NUM_RS*X_RFR_WIDTH-1:0]   rs_q;
   logic [X_ID_WIDTH-1:0]             id_q, next_id_q;
   logic                              accept_q, kill_q;
   logic [NUM_IDS-1:0]                table_q;
   logic [CW-1:0]                     count_q, count_d;
   logic                              wb_valid_q, wb_we_q, wb_exc_q, proto_err_q;
   logic [4:0]                        wb_rd_q;
   logic [31:0]                       wb_data_q;
   logic [5:0]                        wb_exccode_q;
   logic                              off_hs, add, remove, res_hs;

   // The writeback hint carries no information this initiator acts on.
   logic unused_writeback;
   assign unused_writeback = issue_resp_writeback_i;

   assign off_ready_o    = (state_q == IDLE) && (count_q < MAX_C);
   assign off_hs         = off_valid_i && off_ready_o;
   assign result_ready_o = !wb_valid_q || wb_ready_i;
   assign res_hs         = result_valid_i && result_ready_o;

   // The ID being committed this cycle cannot legally have a result yet.
   always_comb begin
      add    = (state_q == COMMIT) && accept_q && !kill_q;
      remove = res_hs && table_q[result_id_i] &&
               !((state_q == COMMIT) && (result_id_i == id_q));
      count_d = count_q + CW'(add) - CW'(remove);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         rs_q      <= '0;
         id_q      <= '0;
         next_id_q <= '0;
         accept_q  <= 1'b0;
         kill_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               kill_q <= 1'b0;
               if (off_hs) begin
                  instr_q <= off_instr_i;
                  rs_q    <= off_rs_i;
                  id_q    <= next_id_q;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (off_kill_i) kill_q <= 1'b1;
               if (issue_ready_i) begin
                  accept_q  <= issue_resp_accept_i;
                  next_id_q <= next_id_q + X_ID_WIDTH'(1);
                  state_q   <= COMMIT;
               end
            end
            COMMIT: begin
               if (off_kill_i) kill_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         table_q      <= '0;
         count_q      <= '0;
         proto_err_q  <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         wb_we_q      <= 1'b0;
         wb_exc_q     <= 1'b0;
         wb_exccode_q <= '0;
      end else begin
         count_q <= count_d;
         if (add) table_q[id_q] <= 1'b1;
         if (remove) begin
            table_q[result_id_i] <= 1'b0;
            wb_valid_q   <= 1'b1;
            wb_rd_q      <= result_rd_i;
            wb_data_q    <= result_data_i;
            wb_we_q      <= result_we_i;
            wb_exc_q     <= result_exc_i;
            wb_exccode_q <= result_exccode_i;
         end else if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
         end
         if (res_hs && !remove) proto_err_q <= 1'b1;
      end
   end

   assign issue_valid_o        = (state_q == ISSUE);
   assign issue_req_instr_o    = instr_q;
   assign issue_req_mode_o     = 2'b11;
   assign issue_req_id_o       = id_q;
   assign issue_req_rs_o       = rs_q;
   assign issue_req_rs_valid_o = '1;
   assign commit_valid_o       = (state_q == COMMIT);
   assign commit_id_o          = id_q;
   assign commit_kill_o        = (state_q == COMMIT) && (kill_q || !accept_q);
   assign off_done_o           = (state_q == COMMIT);
   assign off_illegal_o        = (state_q == COMMIT) && !accept_q;
   assign wb_valid_o           = wb_valid_q;
   assign wb_rd_o              = wb_rd_q;
   assign wb_data_o            = wb_data_q;
   assign wb_we_o              = wb_we_q;
   assign wb_exc_o             = wb_exc_q;
   assign wb_exccode_o         = wb_exccode_q;
   assign outstanding_o        = count_q;
   assign proto_err_o          = proto_err_q;

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Directed bench for xif_offload_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_xif_offload_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        off_valid_i, off_ready_o, off_kill_i, off_done_o, off_illegal_o;
   logic [31:0] off_instr_i;
   logic [63:0] off_rs_i;
   logic        issue_valid_o, issue_ready_i;
   logic [31:0] issue_req_instr_o;
   logic [1:0]  issue_req_mode_o;
   logic [3:0]  issue_req_id_o;
   logic [63:0] issue_req_rs_o;
   logic [1:0]  issue_req_rs_valid_o;
   logic        issue_resp_accept_i, issue_resp_writeback_i;
   logic        commit_valid_o, commit_kill_o;
   logic [3:0]  commit_id_o;
   logic        result_valid_i, result_ready_o;
   logic [3:0]  result_id_i;
   logic [31:0] result_data_i;
   logic [4:0]  result_rd_i;
   logic        result_we_i, result_exc_i;
   logic [5:0]  result_exccode_i;
   logic        wb_valid_o, wb_ready_i;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        wb_we_o, wb_exc_o;
   logic [5:0]  wb_exccode_o;
   logic [2:0]  outstanding_o;
   logic        proto_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   xif_offload_ctrl #(.X_NUM_RS(2), .X_ID_WIDTH(4), .X_RFR_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .off_valid_i(off_valid_i), .off_ready_o(off_ready_o), .off_instr_i(off_instr_i),
      .off_rs_i(off_rs_i), .off_kill_i(off_kill_i), .off_done_o(off_done_o),
      .off_illegal_o(off_illegal_o),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .issue_req_instr_o(issue_req_instr_o), .issue_req_mode_o(issue_req_mode_o),
      .issue_req_id_o(issue_req_id_o), .issue_req_rs_o(issue_req_rs_o),
      .issue_req_rs_valid_o(issue_req_rs_valid_o),
      .issue_resp_accept_i(issue_resp_accept_i), .issue_resp_writeback_i(issue_resp_writeback_i),
      .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
      .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
      .result_id_i(result_id_i), .result_data_i(result_data_i), .result_rd_i(result_rd_i),
      .result_we_i(result_we_i), .result_exc_i(result_exc_i), .result_exccode_i(result_exccode_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
      .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_exc_o(wb_exc_o),
      .wb_exccode_o(wb_exccode_o), .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we, exc;
      logic [5:0]  code;
   } wb_t;

   int          m_ph;  // 0 waiting for request, 1 issuing, 2 committing
   logic [3:0]  m_id, m_next;
   logic        m_acc, m_kill, m_perr;
   logic        m_tab [16];
   logic [31:0] m_instr;
   logic [63:0] m_rs;
   wb_t         wbq [$];
   int          c0;
   logic        rr, known;
   wb_t         rec;

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < 16; i++) if (m_tab[i]) c++;
      return c;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_ph = 0; m_id = '0; m_next = '0; m_acc = 1'b0; m_kill = 1'b0; m_perr = 1'b0;
         m_instr = '0; m_rs = '0;
         for (int i = 0; i < 16; i++) m_tab[i] = 1'b0;
         wbq.delete();
      end else begin
         c0 = m_cnt();
         rr = (wbq.size() == 0) || wb_ready_i;
         if (wbq.size() != 0 && wb_ready_i) void'(wbq.pop_front());
         if (result_valid_i && rr) begin
            known = m_tab[result_id_i] && !(m_ph == 2 && result_id_i == m_id);
            if (known) begin
               m_tab[result_id_i] = 1'b0;
               rec.rd = result_rd_i; rec.data = result_data_i; rec.we = result_we_i;
               rec.exc = result_exc_i; rec.code = result_exccode_i;
               wbq.push_back(rec);
            end else m_perr = 1'b1;
         end
         case (m_ph)
            0: begin
               m_kill = 1'b0;
               if (off_valid_i && c0 < 4) begin
                  m_id = m_next; m_instr = off_instr_i; m_rs = off_rs_i; m_ph = 1;
               end
            end
            1: begin
               if (off_kill_i) m_kill = 1'b1;
               if (issue_ready_i) begin
                  m_acc = issue_resp_accept_i; m_next = m_next + 4'd1; m_ph = 2;
               end
            end
            default: begin
               if (m_acc && !m_kill) m_tab[m_id] = 1'b1;
               m_ph = 0;
            end
         endcase
      end
   end

   always @(negedge clk_i) begin
      chk("off_ready", off_ready_o, (m_ph == 0 && m_cnt() < 4));
      chk("issue_valid", issue_valid_o, (m_ph == 1));
      chk("commit_valid", commit_valid_o, (m_ph == 2));
      chk("off_done", off_done_o, (m_ph == 2));
      chk("mode", issue_req_mode_o, 2'b11);
      chk("rs_valid", issue_req_rs_valid_o, 2'b11);
      chk("outstanding", outstanding_o, m_cnt());
      chk("result_ready", result_ready_o, (wbq.size() == 0) || wb_ready_i);
      chk("wb_valid", wb_valid_o, wbq.size() != 0);
      chk("proto_err", proto_err_o, m_perr);
      if (m_ph == 1) begin
         chk("issue_id", issue_req_id_o, m_id);
         chk("issue_instr", issue_req_instr_o, m_instr);
         chk("issue_rs", issue_req_rs_o, m_rs);
      end
      if (m_ph == 2) begin
         chk("commit_id", commit_id_o, m_id);
         chk("commit_kill", commit_kill_o, m_kill || !m_acc);
         chk("off_illegal", off_illegal_o, !m_acc);
      end
      if (wbq.size() != 0) begin
         chk("wb_rd", wb_rd_o, wbq[0].rd);
         chk("wb_data", wb_data_o, wbq[0].data);
         chk("wb_we", wb_we_o, wbq[0].we);
         chk("wb_exc", wb_exc_o, wbq[0].exc);
         chk("wb_exccode", wb_exccode_o, wbq[0].code);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offload(input logic [31:0] instr, input logic [31:0] r0, input logic [31:0] r1,
                          input logic acc, input int stall, input logic kill,
                          output int iv, output logic ckill, output logic cill,
                          output logic [3:0] cid, output logic cseen);
      off_instr_i = instr; off_rs_i = {r1, r0}; off_valid_i = 1'b1; issue_resp_accept_i = acc;
      step();
      off_valid_i = 1'b0;
      iv = 0;
      for (int i = 0; i < stall; i++) begin
         off_kill_i = kill;
         if (issue_valid_o) iv++;
         step();
      end
      off_kill_i = 1'b0; issue_ready_i = 1'b1;
      if (issue_valid_o) iv++;
      step();
      issue_ready_i = 1'b0;
      cseen = commit_valid_o; ckill = commit_kill_o; cill = off_illegal_o; cid = commit_id_o;
      step();
   endtask

   task automatic send_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                              input logic exc, input logic [5:0] code);
      int n = 0;
      result_valid_i = 1'b1; result_id_i = id; result_data_i = data; result_rd_i = rd;
      result_we_i = 1'b1; result_exc_i = exc; result_exccode_i = code;
      #1;
      while (!result_ready_o && n < 20) begin
         step();
         n++;
      end
      chk("result_wait_budget", (n < 20), 1'b1);
      step();
      result_valid_i = 1'b0;
   endtask

   int         iv;
   logic       ck, ci, cs;
   logic [3:0] cid;

   initial begin
      rst_ni = 1'b0;
      off_valid_i = 0; off_instr_i = '0; off_rs_i = '0; off_kill_i = 0;
      issue_ready_i = 0; issue_resp_accept_i = 0; issue_resp_writeback_i = 0;
      result_valid_i = 0; result_id_i = '0; result_data_i = '0; result_rd_i = '0;
      result_we_i = 0; result_exc_i = 0; result_exccode_i = '0; wb_ready_i = 1'b1;
      #2;
      chk("rst_off_ready", off_ready_o, 1'b1);
      chk("rst_result_ready", result_ready_o, 1'b1);
      chk("rst_mode", issue_req_mode_o, 2'b11);
      chk("rst_rs_valid", issue_req_rs_valid_o, 2'b11);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_issue_valid", issue_valid_o, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step();

      // accepted instruction then its result
      offload(32'h0000000A, 32'd1, 32'd2, 1'b1, 0, 1'b0, iv, ck, ci, cid, cs);
      chk("t1_commit_seen", cs, 1'b1);
      chk("t1_commit_id", cid, 4'd0);
      chk("t1_commit_kill", ck, 1'b0);
      chk("t1_outstanding", outstanding_o, 3'd1);
      send_result(4'd0, 32'hDEADBEEF, 5'd5, 1'b0, 6'd0);
      chk("t1_wb_valid", wb_valid_o, 1'b1);
      chk("t1_wb_rd", wb_rd_o, 5'd5);
      chk("t1_wb_data", wb_data_o, 32'hDEADBEEF);
      chk("t1_outstanding0", outstanding_o, 3'd0);
      step();

      // rejected instruction
      offload(32'h0000000B, 32'd3, 32'd4, 1'b0, 0, 1'b0, iv, ck, ci, cid, cs);
      chk("rej_kill", ck, 1'b1);
      chk("rej_illegal", ci, 1'b1);
      chk("rej_id", cid, 4'd1);
      chk("rej_outstanding", outstanding_o, 3'd0);

      // fill the table
      for (int k = 0; k < 4; k++) begin
         offload(32'h100 + k, k, k + 1, 1'b1, 0, 1'b0, iv, ck, ci, cid, cs);
         chk("fill_id", cid, 4'd2 + 4'(k));
      end
      chk("full_off_ready", off_ready_o, 1'b0);
      chk("full_outstanding", outstanding_o, 3'd4);
      send_result(4'd2, 32'h22222222, 5'd2, 1'b0, 6'd0);
      chk("freed_off_ready", off_ready_o, 1'b1);
      chk("freed_outstanding", outstanding_o, 3'd3);

      // kill while issue stalls for 3 cycles
      offload(32'h0000000C, 32'd7, 32'd8, 1'b1, 3, 1'b1, iv, ck, ci, cid, cs);
      chk("kill_iv_cycles", iv, 4);
      chk("kill_commit_kill", ck, 1'b1);
      chk("kill_illegal", ci, 1'b0);
      chk("kill_id", cid, 4'd6);
      chk("kill_outstanding", outstanding_o, 3'd3);

      // unknown ID
      send_result(4'd7, 32'h77777777, 5'd9, 1'b1, 6'h11);
      chk("unk_wb_valid", wb_valid_o, 1'b0);
      chk("unk_proto_err", proto_err_o, 1'b1);
      step();

      // writeback back-pressure
      wb_ready_i = 1'b0;
      send_result(4'd3, 32'h33333333, 5'd3, 1'b1, 6'h2A);
      chk("bp_wb_data", wb_data_o, 32'h33333333);
      chk("bp_wb_exc", wb_exc_o, 1'b1);
      chk("bp_wb_code", wb_exccode_o, 6'h2A);
      result_valid_i = 1'b1; result_id_i = 4'd4; result_data_i = 32'h44444444;
      result_rd_i = 5'd4; result_exc_i = 1'b0; result_exccode_i = '0;
      #1 chk("bp_ready_low0", result_ready_o, 1'b0);
      step();
      chk("bp_ready_low1", result_ready_o, 1'b0);
      chk("bp_held_data", wb_data_o, 32'h33333333);
      wb_ready_i = 1'b1;
      #1 chk("bp_ready_high", result_ready_o, 1'b1);
      step();
      result_valid_i = 1'b0;
      chk("bp_second_data", wb_data_o, 32'h44444444);
      chk("bp_outstanding", outstanding_o, 3'd1);
      step();

      // ID wrap across 17 issues
      for (int k = 0; k < 10; k++) begin
         offload(32'h200 + k, 0, 0, 1'b0, 0, 1'b0, iv, ck, ci, cid, cs);
         if (k == 8) chk("wrap_id15", cid, 4'd15);
         if (k == 9) chk("wrap_id0", cid, 4'd0);
      end
      send_result(4'd5, 32'h55555555, 5'd6, 1'b0, 6'd0);
      chk("end_outstanding", outstanding_o, 3'd0);
      chk("sticky_proto_err", proto_err_o, 1'b1);
      step();

      // reset mid-transaction
      off_instr_i = 32'hABCD; off_valid_i = 1'b1;
      step();
      off_valid_i = 1'b0;
      chk("mid_issue_valid", issue_valid_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_issue", issue_valid_o, 1'b0);
      chk("mid_rst_commit", commit_valid_o, 1'b0);
      chk("mid_rst_proto", proto_err_o, 1'b0);
      step();
      rst_ni = 1'b1;
      step();
      chk("post_rst_commit", commit_valid_o, 1'b0);
      chk("post_rst_ready", off_ready_o, 1'b1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
